// File: rtl/ysyx_201979054_cache_transfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_201979054_cache_transfer_arbiter
// Brief    : Round-robin owner of the shared cache<->AXI block-transfer
//            datapath; dirty D-cache victims are written back before refill.
//            Optional burst watchdog enabled by defining TRANSFER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_201979054_cache_transfer_arbiter #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      i_icache_req,
    input  logic [AXI_ADDR_WIDTH-1:0] i_icache_addr,
    input  logic                      i_dcache_req,
    input  logic                      i_dcache_dirty,
    input  logic [AXI_ADDR_WIDTH-1:0] i_dcache_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] i_dcache_wb_addr,
    input  logic                      i_count_done,
    output logic                      o_start_read,
    output logic                      o_start_write,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr_cache,
    output logic                      o_axi_read_req,
    output logic                      o_axi_write_req,
    output logic                      o_owner,
    output logic                      o_busy,
    output logic                      o_refill_we,
    output logic                      o_icache_done,
    output logic                      o_dcache_done,
    output logic                      o_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WB_START = 3'd1,
        S_WB_RUN   = 3'd2,
        S_RF_START = 3'd3,
        S_RF_RUN   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                    r_state;
    logic                      r_owner;
    logic                      r_dirty;
    logic                      r_rr;
    logic [AXI_ADDR_WIDTH-1:0] r_refill_addr;
    logic [AXI_ADDR_WIDTH-1:0] r_wb_addr;
    logic                      w_grant_d;
    logic                      w_timeout;
    logic                      w_in_wb;

    // D-cache wins when it is the only requester or the rr pointer names it.
    assign w_grant_d = i_dcache_req && (!i_icache_req || r_rr);

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_dirty       <= 1'b0;
            r_rr          <= 1'b0;
            r_refill_addr <= '0;
            r_wb_addr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_icache_req || i_dcache_req) begin
                        r_owner       <= w_grant_d;
                        r_dirty       <= w_grant_d && i_dcache_dirty;
                        r_refill_addr <= w_grant_d ? i_dcache_addr : i_icache_addr;
                        r_wb_addr     <= i_dcache_wb_addr;
                        r_state       <= (w_grant_d && i_dcache_dirty) ? S_WB_START : S_RF_START;
                    end
                end
                S_WB_START: r_state <= S_WB_RUN;
                S_WB_RUN: begin
                    if (i_count_done)
                        r_state <= S_RF_START;
                    else if (w_timeout)
                        r_state <= S_DONE;
                end
                S_RF_START: r_state <= S_RF_RUN;
                S_RF_RUN: begin
                    if (i_count_done || w_timeout)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_rr    <= ~r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TRANSFER_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err;

    assign w_timeout = ((r_state == S_WB_RUN) || (r_state == S_RF_RUN)) &&
                       !i_count_done && (r_to_cnt == c_TO_LIMIT);

    always_ff @(posedge clk) begin
        if (arst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == S_WB_START) || (r_state == S_RF_START))
                r_to_cnt <= '0;
            else if ((r_state == S_WB_RUN) || (r_state == S_RF_RUN))
                r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state == S_IDLE)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign o_error = (r_state == S_DONE) && r_err;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign o_error          = 1'b0;
`endif

    assign w_in_wb = (r_state == S_WB_START) || (r_state == S_WB_RUN);

    assign o_start_write   = (r_state == S_WB_START);
    assign o_start_read    = (r_state == S_RF_START);
    assign o_axi_write_req = (r_state == S_WB_RUN);
    assign o_axi_read_req  = (r_state == S_RF_RUN);
    assign o_busy          = (r_state != S_IDLE);
    assign o_owner         = r_owner;
    assign o_addr_cache    = (w_in_wb && r_dirty) ? r_wb_addr :
                             (o_busy ? r_refill_addr : '0);
    // A timed-out transfer still completes, but its block must not be written.
    assign o_refill_we     = (r_state == S_DONE) && !o_error;
    assign o_icache_done   = (r_state == S_DONE) && !r_owner;
    assign o_dcache_done   = (r_state == S_DONE) && r_owner;

endmodule
`default_nettype wire
